vend_credit: RTL and testbench

Parametrised coin-accumulating vending controller, the next generation of the 3-bit nickel/dime vend FSM.
- Generalised to a configurable price and coin values, with a quarter input, a cancel/refund button, and serial change return in nickels.
- Handles illegal coin combinations explicitly.
- Sits between the coin-acceptor pulse synchronisers and the dispense/change solenoid drivers.

---
 rtl/vend_credit.sv | 112 +++++++++++
 tb/tb_vend_credit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vend_credit.sv
// Coin-accumulating vending controller: collects nickels/dimes/quarters, dispenses
// one item at PRICE, then refunds any excess (or a cancelled credit) one nickel per cycle.
module vend_credit #(
   parameter int PRICE       = 15,
   parameter int NICKEL_VAL  = 5,
   parameter int DIME_VAL    = 10,
   parameter int QUARTER_VAL = 25,
   parameter int CREDIT_W    = 6
) (
   input  logic                CLK,
   input  logic                Reset,
   input  logic                Nickel,
   input  logic                Dime,
   input  logic                Quarter,
   input  logic                Cancel,
   output logic                Dispense,
   output logic                ChangeNickel,
   output logic                CoinReject,
   output logic [CREDIT_W-1:0] Credit,
   output logic [1:0]          State
);

   // Coin inputs are single-cycle pulses sampled on the rising edge; there is no
   // back-pressure, so a pulse that cannot be accepted is answered by CoinReject.
   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      VEND    = 2'd1,
      CHANGE  = 2'd2,
      ILLEGAL = 2'd3
   } state_t;

   localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(NICKEL_VAL);
   localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(DIME_VAL);
   localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(QUARTER_VAL);

   state_t              state, state_nxt;
   logic [CREDIT_W-1:0] credit, credit_nxt;
   logic                reject, reject_nxt;
   logic                any_coin, one_coin;
   logic [CREDIT_W-1:0] coin_val;

   assign any_coin = Nickel | Dime | Quarter;
   assign one_coin = (Nickel ^ Dime ^ Quarter) & ~(Nickel & Dime & Quarter);

   always_comb begin
      coin_val = QUARTER_C;
      if (Nickel)
         coin_val = NICKEL_C;
      else if (Dime)
         coin_val = DIME_C;
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state  <= COLLECT;
         credit <= '0;
         reject <= 1'b0;
      end else begin
         state  <= state_nxt;
         credit <= credit_nxt;
         reject <= reject_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      credit_nxt = credit;
      reject_nxt = 1'b0;
      case (state)
         COLLECT: begin
            // Cancel outranks coins so a refund never races with a late insertion.
            if (Cancel) begin
               reject_nxt = any_coin;
               if (credit != '0)
                  state_nxt = CHANGE;
            end else if (one_coin) begin
               credit_nxt = credit + coin_val;
               if (credit_nxt >= PRICE_C)
                  state_nxt = VEND;
            end else if (any_coin) begin
               reject_nxt = 1'b1;
            end
         end
         VEND: begin
            reject_nxt = any_coin;
            credit_nxt = credit - PRICE_C;
            state_nxt  = (credit_nxt != '0) ? CHANGE : COLLECT;
         end
         CHANGE: begin
            reject_nxt = any_coin;
            if (credit <= NICKEL_C) begin
               credit_nxt = '0;
               state_nxt  = COLLECT;
            end else begin
               credit_nxt = credit - NICKEL_C;
            end
         end
         default: begin
            state_nxt  = COLLECT;
            credit_nxt = '0;
         end
      endcase
   end

   assign Dispense     = (state == VEND);
   assign ChangeNickel = (state == CHANGE);
   assign CoinReject   = reject;
   assign Credit       = credit;
   assign State        = state;

endmodule

// File: tb/tb_vend_credit.sv
// Directed bench for vend_credit: hand-computed credit/state/pulse expectations for
// each purchase, refund, reject and asynchronous-reset scenario.
module tb_vend_credit;

   localparam int CREDIT_W = 6;

   logic                CLK;
   logic                Reset;
   logic                Nickel, Dime, Quarter, Cancel;
   logic                Dispense, ChangeNickel, CoinReject;
   logic [CREDIT_W-1:0] Credit;
   logic [1:0]          State;

   int n_checks = 0;
   int n_pass   = 0;
   int disp_cnt = 0;
   int chg_cnt  = 0;
   int disp_base, chg_base;
   logic [CREDIT_W-1:0] exp_q[$];

   vend_credit #(
      .PRICE(15), .NICKEL_VAL(5), .DIME_VAL(10), .QUARTER_VAL(25), .CREDIT_W(CREDIT_W)
   ) dut (
      .CLK(CLK), .Reset(Reset),
      .Nickel(Nickel), .Dime(Dime), .Quarter(Quarter), .Cancel(Cancel),
      .Dispense(Dispense), .ChangeNickel(ChangeNickel), .CoinReject(CoinReject),
      .Credit(Credit), .State(State)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // pulse monitor: Moore outputs sampled mid-cycle
   always @(negedge CLK) begin
      if (Dispense)     disp_cnt++;
      if (ChangeNickel) chg_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic n, input logic d, input logic q, input logic c);
      Nickel = n; Dime = d; Quarter = q; Cancel = c;
      tick();
      Nickel = 1'b0; Dime = 1'b0; Quarter = 1'b0; Cancel = 1'b0;
   endtask

   task automatic check_sc(input string tag, input logic [1:0] st, input logic [CREDIT_W-1:0] cr);
      check({tag, "_state"}, State, st);
      check({tag, "_credit"}, Credit, cr);
   endtask

   task automatic mark();
      disp_base = disp_cnt;
      chg_base  = chg_cnt;
   endtask

   initial begin
      Reset = 1'b0;
      Nickel = 1'b0; Dime = 1'b0; Quarter = 1'b0; Cancel = 1'b0;
      #2;
      check_sc("rst", 2'd0, 6'd0);
      check("rst_disp", Dispense, 1'b0);
      check("rst_chg", ChangeNickel, 1'b0);
      check("rst_rej", CoinReject, 1'b0);
      @(posedge CLK); #1;
      Reset = 1'b1;
      tick();

      // 1: three nickels reach the price exactly
      mark();
      drive(1, 0, 0, 0); check_sc("t1_n1", 2'd0, 6'd5);
      drive(1, 0, 0, 0); check_sc("t1_n2", 2'd0, 6'd10);
      drive(1, 0, 0, 0); check_sc("t1_n3", 2'd1, 6'd15);
      check("t1_disp", Dispense, 1'b1);
      tick();            check_sc("t1_end", 2'd0, 6'd0);
      check("t1_disp_off", Dispense, 1'b0);
      tick();
      check("t1_disp_cnt", disp_cnt - disp_base, 1);
      check("t1_chg_cnt", chg_cnt - chg_base, 0);

      // 2: quarter overpays by 10 -> two nickels back
      mark();
      exp_q.push_back(6'd25); exp_q.push_back(6'd10);
      exp_q.push_back(6'd5);  exp_q.push_back(6'd0);
      drive(0, 0, 1, 0);
      check("t2_credit0", Credit, exp_q.pop_front());
      check("t2_vend", State, 2'd1);
      tick(); check("t2_credit1", Credit, exp_q.pop_front());
      check("t2_chg1", ChangeNickel, 1'b1);
      tick(); check("t2_credit2", Credit, exp_q.pop_front());
      check("t2_chg2", ChangeNickel, 1'b1);
      tick(); check("t2_credit3", Credit, exp_q.pop_front());
      check("t2_state_end", State, 2'd0);
      tick();
      check("t2_disp_cnt", disp_cnt - disp_base, 1);
      check("t2_chg_cnt", chg_cnt - chg_base, 2);

      // 3: dime then cancel with a simultaneous nickel
      mark();
      drive(0, 1, 0, 0); check_sc("t3_dime", 2'd0, 6'd10);
      drive(1, 0, 0, 1); check_sc("t3_cancel", 2'd2, 6'd10);
      check("t3_rej", CoinReject, 1'b1);
      tick(); check_sc("t3_chg", 2'd2, 6'd5);
      check("t3_rej_off", CoinReject, 1'b0);
      tick(); check_sc("t3_end", 2'd0, 6'd0);
      tick();
      check("t3_disp_cnt", disp_cnt - disp_base, 0);
      check("t3_chg_cnt", chg_cnt - chg_base, 2);

      // 4: two coins at once are refused
      drive(1, 0, 0, 0); check_sc("t4_n", 2'd0, 6'd5);
      drive(1, 1, 0, 0); check_sc("t4_dual", 2'd0, 6'd5);
      check("t4_rej", CoinReject, 1'b1);
      drive(0, 0, 0, 1); check_sc("t4_cancel", 2'd2, 6'd5);
      check("t4_rej_off", CoinReject, 1'b0);
      tick(); check_sc("t4_end", 2'd0, 6'd0);

      // cancel with no credit is a no-op
      drive(0, 0, 0, 1); check_sc("t4b_cancel0", 2'd0, 6'd0);
      check("t4b_rej", CoinReject, 1'b0);

      // 5: quarter during VEND is refused, cancel ignored
      mark();
      drive(0, 1, 0, 0); check_sc("t5_d1", 2'd0, 6'd10);
      drive(0, 1, 0, 0); check_sc("t5_d2", 2'd1, 6'd20);
      drive(0, 0, 1, 1); check_sc("t5_vend", 2'd2, 6'd5);
      check("t5_rej", CoinReject, 1'b1);
      tick(); check_sc("t5_end", 2'd0, 6'd0);
      check("t5_rej_off", CoinReject, 1'b0);
      tick();
      check("t5_disp_cnt", disp_cnt - disp_base, 1);
      check("t5_chg_cnt", chg_cnt - chg_base, 1);

      // 6: asynchronous reset in the middle of the first CHANGE cycle
      drive(0, 0, 1, 0); check_sc("t6_q", 2'd1, 6'd25);
      tick();            check_sc("t6_chg", 2'd2, 6'd10);
      #2;
      Reset = 1'b0;
      #1;
      check_sc("t6_async", 2'd0, 6'd0);
      check("t6_chg_off", ChangeNickel, 1'b0);
      check("t6_disp_off", Dispense, 1'b0);
      mark();
      tick();
      Reset = 1'b1;
      repeat (4) tick();
      check_sc("t6_after", 2'd0, 6'd0);
      check("t6_chg_cnt", chg_cnt - chg_base, 0);
      check("t6_disp_cnt", disp_cnt - disp_base, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
